// File: rtl/prog_rom_pkg.sv
// prog_rom_pkg: shared constants and FSM state type for the program ROM.
// Optional build macro used by prog_rom: PROG_ROM_OUTREG_EN (extra output register stage).
package prog_rom_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 15;
   localparam int DEF_DEPTH  = 32768;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } state_t;

endpackage

// File: rtl/rom_mem.sv
// rom_mem: zero-initialised storage array with one synchronous write port and
// one synchronous read port. Addresses at or beyond DEPTH read back as zero.
module rom_mem #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 15,
   parameter int DEPTH  = 32768
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   // Power-up contents are zero; reset never touches the array.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
   logic [DATA_W-1:0] rd_word_q;
   logic              rd_oor_q;

   // Write port: the writer guarantees wr_addr_i < DEPTH.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   // Read port: registered read, holds its word between reads.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) begin
         rd_word_q <= mem[rd_addr_i];
         rd_oor_q  <= ({1'b0, rd_addr_i} >= DEPTH_L);
      end
   end

   assign rd_data_o = rd_oor_q ? '0 : rd_word_q;

endmodule

// File: rtl/prog_rom.sv
// prog_rom: loadable program ROM. A streamed load (valid/ready) fills the
// array from address 0; reads are accepted only outside a load.
// Build macro: PROG_ROM_OUTREG_EN adds an output register (read latency 2).
module prog_rom
   import prog_rom_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] data_o,
   output logic              rd_valid_o,
   input  logic              load_start_i,
   input  logic [ADDR_W:0]   load_len_i,
   input  logic              load_valid_i,
   input  logic [DATA_W-1:0] load_data_i,
   output logic              load_ready_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic              wr_en;
   logic              rd_acc;
   logic              rd_valid_q;
   logic              have_data_q;
   logic [DATA_W-1:0] mem_rd_data;
   logic [DATA_W-1:0] rd_data_s1;

   // FSM state, write pointer and latched load length.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         wptr_q  <= '0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         len_q   <= len_d;
      end
   end

   // Next state: start a load (clamped to DEPTH), count written words.
   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      len_d   = len_q;
      case (state_q)
         ST_IDLE, ST_READY: begin
            if (load_start_i) begin
               wptr_d  = '0;
               len_d   = (load_len_i > DEPTH_L) ? DEPTH_L : load_len_i;
               state_d = (load_len_i == '0) ? ST_READY : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (load_valid_i) begin
               wptr_d = wptr_q + 1'b1;
               if (wptr_q == len_q - 1'b1) begin
                  state_d = ST_READY;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from state; a load start wins over a same-cycle read.
   always_comb begin
      load_ready_o = (state_q == ST_LOAD);
      busy_o       = (state_q == ST_LOAD);
      done_o       = (state_q == ST_READY);
      wr_en        = (state_q == ST_LOAD) && load_valid_i;
      rd_acc       = rd_en_i && !load_start_i && (state_q != ST_LOAD);
   end

   rom_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i     (clk_i),
      .wr_en_i   (wr_en),
      .wr_addr_i (wptr_q[ADDR_W-1:0]),
      .wr_data_i (load_data_i),
      .rd_en_i   (rd_acc),
      .rd_addr_i (addr_i),
      .rd_data_o (mem_rd_data)
   );

   // Read valid tracking; have_data_q masks the unreset memory read register
   // so data_o is zero until the first read after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_valid_q  <= 1'b0;
         have_data_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            have_data_q <= 1'b1;
         end
      end
   end

   assign rd_data_s1 = have_data_q ? mem_rd_data : '0;

`ifdef PROG_ROM_OUTREG_EN
   logic [DATA_W-1:0] data_q;
   logic              rd_valid2_q;

   // Extra output stage: delays data and valid together by one cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q      <= '0;
         rd_valid2_q <= 1'b0;
      end else begin
         rd_valid2_q <= rd_valid_q;
         if (rd_valid_q) begin
            data_q <= rd_data_s1;
         end
      end
   end

   assign data_o     = data_q;
   assign rd_valid_o = rd_valid2_q;
`else
   assign data_o     = rd_data_s1;
   assign rd_valid_o = rd_valid_q;
`endif

endmodule

// File: tb/tb_prog_rom.sv
// tb_prog_rom: directed bench for prog_rom with a read scoreboard.
// Reads push expected word and due cycle; a monitor pops on rd_valid_o.
module tb_prog_rom;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int DP = 8;
`ifdef PROG_ROM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      logic [DW-1:0] data;
      int            due;
      int            addr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          rd_en_i;
   logic [AW-1:0] addr_i;
   logic [DW-1:0] data_o;
   logic          rd_valid_o;
   logic          load_start_i;
   logic [AW:0]   load_len_i;
   logic          load_valid_i;
   logic [DW-1:0] load_data_i;
   logic          load_ready_o;
   logic          busy_o;
   logic          done_o;

   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;
   exp_t sb[$];
   logic [DW-1:0] words [16];

   prog_rom #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .rd_en_i      (rd_en_i),
      .addr_i       (addr_i),
      .data_o       (data_o),
      .rd_valid_o   (rd_valid_o),
      .load_start_i (load_start_i),
      .load_len_i   (load_len_i),
      .load_valid_i (load_valid_i),
      .load_data_i  (load_data_i),
      .load_ready_o (load_ready_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end else begin
         $display("ok   %s = %h (cycle %0d)", nm, act, cyc);
      end
   endtask

   // Issue one accepted read at the current negedge, then advance a cycle.
   task automatic rd(input int a, input logic [DW-1:0] e);
      exp_t x;
      rd_en_i = 1'b1;
      addr_i  = a[AW-1:0];
      x.data = e;
      x.due  = cyc + LAT;
      x.addr = a;
      sb.push_back(x);
      @(negedge clk);
   endtask

   task automatic rd_idle();
      rd_en_i = 1'b0;
      @(negedge clk);
   endtask

   // Start a load and stream words[] while busy; optional idle beat every other cycle.
   task automatic do_load(input int len, input int nw, input bit gap, output int acc);
      int k;
      acc = 0;
      k   = 0;
      load_start_i = 1'b1;
      load_len_i   = len[AW:0];
      @(negedge clk);
      load_start_i = 1'b0;
      for (int t = 0; t < 200; t++) begin
         if (done_o) break;
         if (busy_o && k < nw && !(gap && t[0])) begin
            load_valid_i = 1'b1;
            load_data_i  = words[k];
            if (load_ready_o) begin
               acc++;
               k++;
            end
         end else begin
            load_valid_i = 1'b0;
            load_data_i  = 16'hDEAD;
         end
         @(negedge clk);
      end
      load_valid_i = 1'b0;
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            n_chk++;
            n_err++;
            $display("FAIL rd_missing addr=%0d actual=no-valid expected=%h due=%0d", e.addr, e.data, e.due);
         end
         if (rd_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL rd_unexpected actual=valid data=%h expected=no-valid (cycle %0d)", data_o, cyc);
            end else begin
               e = sb.pop_front();
               n_chk++;
               if (data_o !== e.data || cyc != e.due) begin
                  n_err++;
                  $display("FAIL rd_addr%0d actual=%h@%0d expected=%h@%0d", e.addr, data_o, cyc, e.data, e.due);
               end else begin
                  $display("ok   rd_addr%0d = %h (cycle %0d)", e.addr, data_o, cyc);
               end
            end
         end
      end
   end

   initial begin
      int acc;
      rst_i = 1'b1; rd_en_i = 1'b0; addr_i = '0;
      load_start_i = 1'b0; load_len_i = '0; load_valid_i = 1'b0; load_data_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_ready", load_ready_o, 0);
      chk("rst_rd_valid", rd_valid_o, 0);
      chk("rst_data", data_o, 0);
      rst_i = 1'b0;
      @(negedge clk);

      // Reset in the middle of a 4-word load after two words.
      load_start_i = 1'b1; load_len_i = 5'd4;
      @(negedge clk);
      load_start_i = 1'b0;
      chk("mid_busy", busy_o, 1);
      chk("mid_ready", load_ready_o, 1);
      load_valid_i = 1'b1; load_data_i = 16'h1111;
      @(negedge clk);
      load_data_i = 16'h2222;
      @(negedge clk);
      load_valid_i = 1'b0; rst_i = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_done", done_o, 0);
      chk("midrst_ready", load_ready_o, 0);
      chk("midrst_data", data_o, 0);
      rst_i = 1'b0;
      rd(1, 16'h2222);
      rd(2, 16'h0000);
      rd(0, 16'h1111);
      rd_idle();

      // Basic 3-word load and read-back.
      words[0] = 16'h0002; words[1] = 16'hEC10; words[2] = 16'h0003;
      do_load(3, 3, 1'b0, acc);
      chk("load3_beats", acc, 3);
      chk("load3_done", done_o, 1);
      chk("load3_busy", busy_o, 0);
      chk("load3_ready", load_ready_o, 0);
      rd(0, 16'h0002);
      rd(1, 16'hEC10);
      rd(2, 16'h0003);
      rd_idle();
      repeat (3) @(negedge clk);
      chk("hold_valid", rd_valid_o, 0);
      chk("hold_data", data_o, 16'h0003);
      rd(9, 16'h0000);
      rd(15, 16'h0000);
      rd_idle();

      // Gapped 4-word load.
      words[0] = 16'hA0A0; words[1] = 16'hB1B1; words[2] = 16'hC2C2; words[3] = 16'hD3D3;
      do_load(4, 4, 1'b1, acc);
      chk("gap_beats", acc, 4);
      chk("gap_done", done_o, 1);
      rd(0, 16'hA0A0);
      rd(1, 16'hB1B1);
      rd(2, 16'hC2C2);
      rd(3, 16'hD3D3);
      rd(4, 16'h0000);
      rd_idle();

      // Zero-length load, then load_valid outside LOAD is ignored.
      do_load(0, 0, 1'b0, acc);
      chk("len0_beats", acc, 0);
      chk("len0_done", done_o, 1);
      chk("len0_busy", busy_o, 0);
      load_valid_i = 1'b1; load_data_i = 16'hFFFF;
      repeat (2) @(negedge clk);
      load_valid_i = 1'b0;
      rd(0, 16'hA0A0);
      rd(1, 16'hB1B1);
      rd_idle();

      // Oversized load clamps to DEPTH words.
      for (int i = 0; i < 13; i++) words[i] = 16'h5000 + 16'(i);
      do_load(DP + 5, 13, 1'b0, acc);
      chk("clamp_beats", acc, DP);
      chk("clamp_done", done_o, 1);
      rd(0, 16'h5000);
      rd(7, 16'h5007);
      rd(8, 16'h0000);
      rd_idle();

      // Read with load start is dropped; reads during LOAD are dropped.
      load_start_i = 1'b1; load_len_i = 5'd2; rd_en_i = 1'b1; addr_i = 4'd3;
      @(negedge clk);
      load_start_i = 1'b0;
      chk("rdload_busy", busy_o, 1);
      chk("rdload_valid0", rd_valid_o, 0);
      load_valid_i = 1'b1; load_data_i = 16'h6000;
      @(negedge clk);
      chk("rdload_valid1", rd_valid_o, 0);
      load_data_i = 16'h6001;
      @(negedge clk);
      rd_en_i = 1'b0; load_valid_i = 1'b0;
      chk("rdload_valid2", rd_valid_o, 0);
      chk("rdload_done", done_o, 1);
      @(negedge clk);
      rd(0, 16'h6000);
      rd(1, 16'h6001);
      rd(3, 16'h5003);
      rd_idle();

      repeat (4) @(negedge clk);
      chk("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
